// File: rtl/fpu_req_adapter_if.sv
// Host-side request/response bundle for fpu_req_adapter.
// master = host (drives requests, accepts responses), slave = adapter.
interface fpu_req_adapter_if;
    logic        req_valid_in;
    logic        req_ready_out;
    logic [3:0]  req_opCode_in;
    logic [1:0]  req_roundingMode_in;
    logic [31:0] req_operandA_in;
    logic [31:0] req_operandB_in;
    logic        rsp_valid_out;
    logic        rsp_ready_in;
    logic [31:0] rsp_result_out;
    logic [4:0]  rsp_flags_out;
    logic        rsp_timeout_out;

    modport master (
        output req_valid_in, req_opCode_in, req_roundingMode_in,
               req_operandA_in, req_operandB_in, rsp_ready_in,
        input  req_ready_out, rsp_valid_out, rsp_result_out,
               rsp_flags_out, rsp_timeout_out
    );

    modport slave (
        input  req_valid_in, req_opCode_in, req_roundingMode_in,
               req_operandA_in, req_operandB_in, rsp_ready_in,
        output req_ready_out, rsp_valid_out, rsp_result_out,
               rsp_flags_out, rsp_timeout_out
    );
endinterface

// File: rtl/fpu_req_adapter.sv
// fpu_req_adapter: turns a valid/ready host request into an FPU run pulse
// (fpuReset_out low) and returns the FPU result as a valid/ready response.
// Sequence: IDLE -> SETUP (operands settle one cycle) -> RUN -> RESP.
// Optional watchdog abort in RUN is built only when FPU_ADAPTER_TIMEOUT_EN
// is defined; otherwise RUN waits forever and rsp_timeout_out is tied low.
module fpu_req_adapter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk_in,
    input  logic                 reset_in,
    fpu_req_adapter_if.slave     host,
    output logic                 fpuReset_out,
    output logic [3:0]           fpuOpCode_out,
    output logic [1:0]           fpuRoundingMode_out,
    output logic [31:0]          fpuOperandA_out,
    output logic [31:0]          fpuOperandB_out,
    input  logic                 fpuResultReady_in,
    input  logic [31:0]          fpuResult_in,
    input  logic [4:0]           fpuFlags_in
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_RUN   = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_req_ready;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_result;
    logic [4:0]  r_rsp_flags;
    logic        r_fpu_reset;
    logic [3:0]  r_fpu_opcode;
    logic [1:0]  r_fpu_rm;
    logic [31:0] r_fpu_op_a;
    logic [31:0] r_fpu_op_b;
    logic        r_ready_prev;
    logic        w_complete;

    // Only a 0->1 transition seen while running counts; a level that was
    // already high when RUN began is ignored until it drops and rises again.
    assign w_complete = (r_state == ST_RUN) && fpuResultReady_in && !r_ready_prev;

`ifdef FPU_ADAPTER_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    logic [CNT_W-1:0] r_wd_cnt;
    logic             r_rsp_timeout;
    logic             w_expire;

    // Counter holds the number of RUN cycles already elapsed, so expiry is
    // flagged on the last permitted RUN cycle.
    assign w_expire = (r_state == ST_RUN) && (r_wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    // Previous-cycle sample of the FPU ready line for edge detection.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            r_ready_prev <= 1'b0;
        end else begin
            r_ready_prev <= fpuResultReady_in;
        end
    end

    // Main control FSM with registered handshake and FPU-side outputs.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            r_state      <= ST_IDLE;
            r_req_ready  <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= 32'd0;
            r_rsp_flags  <= 5'd0;
            r_fpu_reset  <= 1'b1;
            r_fpu_opcode <= 4'd0;
            r_fpu_rm     <= 2'd0;
            r_fpu_op_a   <= 32'd0;
            r_fpu_op_b   <= 32'd0;
`ifdef FPU_ADAPTER_TIMEOUT_EN
            r_wd_cnt      <= '0;
            r_rsp_timeout <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_fpu_reset <= 1'b1;
                    if (host.req_valid_in) begin
                        // Fields go straight to the FPU-facing registers and
                        // stay frozen until the next accepted request.
                        r_fpu_opcode <= host.req_opCode_in;
                        r_fpu_rm     <= host.req_roundingMode_in;
                        r_fpu_op_a   <= host.req_operandA_in;
                        r_fpu_op_b   <= host.req_operandB_in;
                        r_req_ready  <= 1'b0;
                        r_state      <= ST_SETUP;
                    end
                end

                ST_SETUP: begin
                    r_fpu_reset <= 1'b0;
`ifdef FPU_ADAPTER_TIMEOUT_EN
                    r_wd_cnt    <= '0;
`endif
                    r_state     <= ST_RUN;
                end

                ST_RUN: begin
                    if (w_complete) begin
                        r_rsp_result <= fpuResult_in;
                        r_rsp_flags  <= fpuFlags_in;
                        r_fpu_reset  <= 1'b1;
                        r_rsp_valid  <= 1'b1;
                        r_state      <= ST_RESP;
`ifdef FPU_ADAPTER_TIMEOUT_EN
                        r_rsp_timeout <= 1'b0;
                    end else if (w_expire) begin
                        // Watchdog abort reports a quiet NaN with invalidOperation.
                        r_rsp_result  <= 32'h7FC0_0000;
                        r_rsp_flags   <= 5'b10000;
                        r_rsp_timeout <= 1'b1;
                        r_fpu_reset   <= 1'b1;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= ST_RESP;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 1'b1;
`endif
                    end
                end

                ST_RESP: begin
                    if (host.rsp_ready_in) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                    r_fpu_reset <= 1'b1;
                end
            endcase
        end
    end

    assign host.req_ready_out  = r_req_ready;
    assign host.rsp_valid_out  = r_rsp_valid;
    assign host.rsp_result_out = r_rsp_result;
    assign host.rsp_flags_out  = r_rsp_flags;
`ifdef FPU_ADAPTER_TIMEOUT_EN
    assign host.rsp_timeout_out = r_rsp_timeout;
`else
    assign host.rsp_timeout_out = 1'b0;
`endif

    assign fpuReset_out        = r_fpu_reset;
    assign fpuOpCode_out       = r_fpu_opcode;
    assign fpuRoundingMode_out = r_fpu_rm;
    assign fpuOperandA_out     = r_fpu_op_a;
    assign fpuOperandB_out     = r_fpu_op_b;

endmodule

// File: tb/tb_fpu_req_adapter.sv
// Testbench for fpu_req_adapter: directed requests, FPU completion driven by
// the bench, expected responses queued at issue and checked by a monitor.
module tb_fpu_req_adapter;

    logic        clk;
    logic        rst_n;
    logic        fpu_reset;
    logic [3:0]  fpu_opcode;
    logic [1:0]  fpu_rm;
    logic [31:0] fpu_op_a;
    logic [31:0] fpu_op_b;
    logic        fpu_rdy;
    logic [31:0] fpu_res;
    logic [4:0]  fpu_flg;

    fpu_req_adapter_if bus ();

    fpu_req_adapter #(.TIMEOUT_CYCLES(8)) dut (
        .clk_in              (clk),
        .reset_in            (rst_n),
        .host                (bus),
        .fpuReset_out        (fpu_reset),
        .fpuOpCode_out       (fpu_opcode),
        .fpuRoundingMode_out (fpu_rm),
        .fpuOperandA_out     (fpu_op_a),
        .fpuOperandB_out     (fpu_op_b),
        .fpuResultReady_in   (fpu_rdy),
        .fpuResult_in        (fpu_res),
        .fpuFlags_in         (fpu_flg)
    );

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  flags;
        logic        timeout;
    } rsp_t;

    rsp_t exp_q[$];
    int   checks    = 0;
    int   failures  = 0;
    int   rsp_seen  = 0;
    int   rsp_exp   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: a response transfers on the next edge when valid&&ready.
    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid_out && bus.rsp_ready_in) begin
            rsp_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp actual=%h required=none", bus.rsp_result_out);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                $display("rsp #%0d result=%h flags=%b timeout=%b", rsp_seen,
                         bus.rsp_result_out, bus.rsp_flags_out, bus.rsp_timeout_out);
                chk("rsp_result", bus.rsp_result_out, e.result);
                chk("rsp_flags", 32'(bus.rsp_flags_out), 32'(e.flags));
                chk("rsp_timeout", 32'(bus.rsp_timeout_out), 32'(e.timeout));
            end
        end
    end

    // Present a request, let it be accepted, then check SETUP and RUN entry.
    task automatic issue(input logic [3:0] op, input logic [1:0] rm,
                         input logic [31:0] a, input logic [31:0] b,
                         input bit push, input rsp_t e);
        bus.req_opCode_in       = op;
        bus.req_roundingMode_in = rm;
        bus.req_operandA_in     = a;
        bus.req_operandB_in     = b;
        bus.req_valid_in        = 1'b1;
        chk("ready_before_accept", 32'(bus.req_ready_out), 32'd1);
        if (push) begin
            exp_q.push_back(e);
            rsp_exp++;
        end
        step();
        bus.req_valid_in = 1'b0;
        $display("req op=%h rm=%h a=%h b=%h", op, rm, a, b);
        chk("setup_fpu_reset", 32'(fpu_reset), 32'd1);
        chk("setup_ready", 32'(bus.req_ready_out), 32'd0);
        chk("setup_opA", fpu_op_a, a);
        chk("setup_opB", fpu_op_b, b);
        chk("setup_opcode", 32'(fpu_opcode), 32'(op));
        chk("setup_rm", 32'(fpu_rm), 32'(rm));
        step();
        chk("run_fpu_reset", 32'(fpu_reset), 32'd0);
    endtask

    // Raise FPU ready with a result; response must be valid the next cycle.
    task automatic complete(input logic [31:0] res, input logic [4:0] flg);
        chk("no_rsp_before_done", 32'(bus.rsp_valid_out), 32'd0);
        fpu_res = res;
        fpu_flg = flg;
        fpu_rdy = 1'b1;
        step();
        chk("rsp_valid_after_done", 32'(bus.rsp_valid_out), 32'd1);
        chk("resp_fpu_reset", 32'(fpu_reset), 32'd1);
        fpu_rdy = 1'b0;
        fpu_res = 32'hBAD0_BAD0;
        fpu_flg = 5'b11111;
    endtask

    task automatic drain();
        bus.rsp_ready_in = 1'b1;
        step();
        chk("idle_after_xfer_valid", 32'(bus.rsp_valid_out), 32'd0);
        chk("idle_after_xfer_ready", 32'(bus.req_ready_out), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst_n                   = 1'b0;
        bus.req_valid_in        = 1'b0;
        bus.req_opCode_in       = 4'h0;
        bus.req_roundingMode_in = 2'h0;
        bus.req_operandA_in     = 32'h0;
        bus.req_operandB_in     = 32'h0;
        bus.rsp_ready_in        = 1'b1;
        fpu_rdy                 = 1'b0;
        fpu_res                 = 32'h0;
        fpu_flg                 = 5'h0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(bus.req_ready_out), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid_out), 32'd0);
        chk("rst_fpu_reset", 32'(fpu_reset), 32'd1);
        chk("rst_opA", fpu_op_a, 32'd0);
        chk("rst_result", bus.rsp_result_out, 32'd0);
        chk("rst_flags", 32'(bus.rsp_flags_out), 32'd0);
        chk("rst_timeout", 32'(bus.rsp_timeout_out), 32'd0);
        rst_n = 1'b1;
        step();

        // MUL 1.0*2.0, truncation, FPU answers 10 cycles into RUN.
        issue(4'h2, 2'h1, 32'h3F80_0000, 32'h4000_0000, 1'b1, '{32'h4000_0000, 5'd0, 1'b0});
        for (int i = 0; i < 9; i++) begin
            step();
            chk("mul_run_hold_reset", 32'(fpu_reset), 32'd0);
        end
        complete(32'h4000_0000, 5'd0);
        drain();

        // ADD 1.0 + -1.0 with 5 cycles of response backpressure.
        bus.rsp_ready_in = 1'b0;
        issue(4'h0, 2'h0, 32'h3F80_0000, 32'hBF80_0000, 1'b1, '{32'h0000_0000, 5'd0, 1'b0});
        step();
        complete(32'h0000_0000, 5'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid_held", 32'(bus.rsp_valid_out), 32'd1);
            chk("bp_result_held", bus.rsp_result_out, 32'h0000_0000);
        end
        drain();

        // Request pulsed during RUN must be ignored.
        issue(4'h2, 2'h0, 32'h40A0_0000, 32'h4000_0000, 1'b1, '{32'h4120_0000, 5'd0, 1'b0});
        bus.req_operandA_in = 32'hDEAD_BEEF;
        bus.req_valid_in    = 1'b1;
        step();
        step();
        bus.req_valid_in = 1'b0;
        chk("ignore_opA", fpu_op_a, 32'h40A0_0000);
        chk("ignore_ready", 32'(bus.req_ready_out), 32'd0);
        complete(32'h4120_0000, 5'b00001);
        exp_q[0].flags = 5'b00001;
        drain();
        step();
        chk("ignore_no_second_rsp", 32'(bus.rsp_valid_out), 32'd0);

        // Reset mid-RUN abandons the operation.
        issue(4'h3, 2'h0, 32'h4040_0000, 32'h0000_0000, 1'b0, '{32'h0, 5'd0, 1'b0});
        step();
        rst_n = 1'b0;
        #1;
        chk("arst_fpu_reset", 32'(fpu_reset), 32'd1);
        chk("arst_ready", 32'(bus.req_ready_out), 32'd1);
        chk("arst_rsp_valid", 32'(bus.rsp_valid_out), 32'd0);
        fpu_rdy = 1'b1;
        step();
        fpu_rdy = 1'b0;
        rst_n = 1'b1;
        step();
        chk("post_rst_rsp_valid", 32'(bus.rsp_valid_out), 32'd0);
        // DIV 3.0 / 1.0 right after the abort.
        issue(4'h3, 2'h2, 32'h4040_0000, 32'h3F80_0000, 1'b1, '{32'h4040_0000, 5'd0, 1'b0});
        repeat (3) step();
        complete(32'h4040_0000, 5'd0);
        drain();

        // FPU ready already high before RUN: needs a fresh rising edge.
        fpu_rdy = 1'b1;
        fpu_res = 32'h1111_1111;
        step();
        issue(4'h1, 2'h3, 32'h4000_0000, 32'h3F80_0000, 1'b1, '{32'h3F80_0000, 5'd0, 1'b0});
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stale_level_no_rsp", 32'(bus.rsp_valid_out), 32'd0);
        end
        fpu_rdy = 1'b0;
        step();
        step();
        complete(32'h3F80_0000, 5'd0);
        drain();

`ifdef FPU_ADAPTER_TIMEOUT_EN
        // FPU never answers: watchdog aborts after 8 RUN cycles.
        begin
            int n;
            issue(4'h2, 2'h0, 32'h3F80_0000, 32'h3F80_0000, 1'b1, '{32'h7FC0_0000, 5'b10000, 1'b1});
            n = 0;
            while (!bus.rsp_valid_out && n < 50) begin
                step();
                n++;
            end
            chk("wd_run_cycles", 32'(n), 32'd8);
            drain();
        end
`endif

        repeat (3) step();
        chk("rsp_count", 32'(rsp_seen), 32'(rsp_exp));
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
